conv_ibuf_ctrl: RTL and testbench
=================================

Name: conv_ibuf_ctrl

Overview:
Upstream sequencer for the convolution input buffer. Accepts a raster-order pixel stream carrying all input channels per beat, drives the buffer's per-channel write enables, and tracks the image row and column. When a full KERNEL_DIM x KERNEL_DIM window is resident, it stalls input and walks the buffer's bit index and bus address. Each (bit, address) chunk is presented to the crossbar tiles under a valid/ready handshake.

Parameters:
DATA_SIZE, 8, bits per activation; number of bit-serial passes per window
IMG_DIM, 28, square image width/height in pixels
KERNEL_DIM, 3, square kernel size
INPUT_CHANNELS, 2, channels delivered per pixel beat
XBAR_SIZE, 128, crossbar rows per tile
BUS_WIDTH, 16, bus bits per tile per chunk
V_CIM_TILES_OUT, ceil(INPUT_CHANNELS*KERNEL_DIM**2 / XBAR_SIZE), derived (default 1)
NUM_ADDR, ceil(INPUT_CHANNELS*KERNEL_DIM**2 / (BUS_WIDTH*V_CIM_TILES_OUT)), derived integer ceiling (default 2)
COUNT_WIDTH, DATA_SIZE==1 ? 1 : $clog2(DATA_SIZE), derived
ADDR_WIDTH, NUM_ADDR<=1 ? 1 : $clog2(NUM_ADDR), derived

Ports:
clk  input  1  clock, all logic on rising edge
rst_n  input  1  reset, asynchronous, active-low
i_valid  input  1  pixel beat valid
o_ready  output  1  pixel beat accepted when i_valid && o_ready
i_data  input  [DATA_SIZE-1:0] x [INPUT_CHANNELS-1:0]  pixel, one word per channel
o_write_enable  output  INPUT_CHANNELS  to buffer: shift enable per channel
o_data  output  [DATA_SIZE-1:0] x [INPUT_CHANNELS-1:0]  to buffer: pass-through of i_data
o_count  output  COUNT_WIDTH  to buffer: bit index of current chunk
o_ibuf_addr  output  ADDR_WIDTH  to buffer: address of current chunk
o_xbar_valid  output  1  chunk on buffer output is valid for crossbars
i_xbar_ready  input  1  crossbars consume chunk
o_xbar_last  output  1  high with the final chunk of a window
o_frame_done  output  1  one-cycle pulse after the last chunk of a frame

Behaviour:
- States: ACCEPT, STREAM.
- Reset (rst_n low, async) forces the following, all registered:
  - state=ACCEPT; row=col=0; o_count=0, o_ibuf_addr=0.
  - o_xbar_valid=0, o_xbar_last=0, o_frame_done=0.
  - o_ready=0 and o_write_enable=0 while rst_n is low.
- ACCEPT:
  - o_ready=1; o_xbar_valid=0.
  - o_write_enable = {INPUT_CHANNELS{i_valid}}, combinational; o_data = i_data, combinational.
  - On an accepted beat at position (row,col): col increments; at col==IMG_DIM-1, col wraps to 0 and row increments; at row==IMG_DIM-1, row wraps to 0.
  - If row>=KERNEL_DIM-1 and col>=KERNEL_DIM-1 (pre-increment), the next state is STREAM, with o_count=0 and o_ibuf_addr=0.
  - Latency: STREAM starts on the cycle after the completing pixel.
- STREAM:
  - o_ready=0; o_write_enable=0; o_xbar_valid=1.
  - o_count and o_ibuf_addr are registered and hold while !i_xbar_ready.
  - On i_xbar_ready: address is the inner loop, bit is the outer loop.
    - o_ibuf_addr increments.
    - At o_ibuf_addr==NUM_ADDR-1: o_ibuf_addr wraps to 0 and o_count increments.
  - o_xbar_last = (o_count==DATA_SIZE-1 && o_ibuf_addr==NUM_ADDR-1), combinational.
  - The handshake on the last chunk returns to ACCEPT, with o_count=0 and o_ibuf_addr=0.
  - Exactly DATA_SIZE*NUM_ADDR beats per window.
- o_frame_done pulses the cycle after the last-chunk handshake of the window anchored at (IMG_DIM-1, IMG_DIM-1).
- Windows per frame: (IMG_DIM-KERNEL_DIM+1)**2. Frames run back to back with no gap. The buffer is not cleared between frames: the row/col gating guarantees a full refill of IMG_DIM*(KERNEL_DIM-1)+KERNEL_DIM pixels before the next window.
- i_valid while in STREAM: ignored, and the data is not consumed.
- Reset mid-STREAM: the window is aborted immediately (o_xbar_valid drops asynchronously). The first window after reset needs a full refill.
- NUM_ADDR==1: o_ibuf_addr stays 0; o_count steps every handshake.

Optional Feature:
CONV_IBUF_CTRL_PERF_EN:
- Defined: adds outputs o_win_cnt [31:0] and o_stall_cnt [31:0].
  - o_win_cnt counts completed windows.
  - o_stall_cnt counts STREAM cycles with !i_xbar_ready.
  - Both reset to 0 and wrap at 2**32.
- Undefined: neither port nor counter exists; behaviour is otherwise identical.

Test Plan:
1. Reset asserted 3 cycles -> all outputs 0; after release, o_ready=1, o_xbar_valid=0.
2. Stream pixels continuously (defaults) -> no o_xbar_valid for the first 58 beats. The 59th pixel (row 2, col 2) -> STREAM next cycle with 16 beats (count,addr) = (0,0),(0,1),(1,0)…(7,1), o_xbar_last only on (7,1).
3. Hold i_xbar_ready low 3 cycles at (3,1) -> o_count=3 and o_ibuf_addr=1 hold, o_ready=0, o_write_enable=0; resumes at (4,0).
4. Full 784-pixel frame with i_xbar_ready=1 -> 676 windows and 10816 handshakes, one o_frame_done. The next frame's first 58 pixels produce no o_xbar_valid.
5. rst_n pulsed low during beat 5 of a window -> o_xbar_valid=0 immediately, o_count=0. The next window starts only after 59 further pixels.
6. With CONV_IBUF_CTRL_PERF_EN and test 3 on one window -> o_stall_cnt=3, o_win_cnt=1.

Source files
------------

// File: rtl/conv_ibuf_ctrl.sv
// conv_ibuf_ctrl: fills the conv input buffer from a raster pixel stream and walks (bit, addr) chunks to the crossbars.
// Optional CONV_IBUF_CTRL_PERF_EN adds window and stall counters.
module conv_ibuf_ctrl #(
  parameter int DATA_SIZE = 8,
  parameter int IMG_DIM = 28,
  parameter int KERNEL_DIM = 3,
  parameter int INPUT_CHANNELS = 2,
  parameter int XBAR_SIZE = 128,
  parameter int BUS_WIDTH = 16,
  localparam int V_CIM_TILES_OUT = (INPUT_CHANNELS*KERNEL_DIM*KERNEL_DIM + XBAR_SIZE - 1) / XBAR_SIZE,
  localparam int NUM_ADDR = (INPUT_CHANNELS*KERNEL_DIM*KERNEL_DIM + BUS_WIDTH*V_CIM_TILES_OUT - 1) / (BUS_WIDTH*V_CIM_TILES_OUT),
  localparam int COUNT_WIDTH = (DATA_SIZE == 1) ? 1 : $clog2(DATA_SIZE),
  localparam int ADDR_WIDTH = (NUM_ADDR <= 1) ? 1 : $clog2(NUM_ADDR)
)(
  input  logic clk,
  input  logic rst_n,
  input  logic i_valid,
  output logic o_ready,
  input  logic [INPUT_CHANNELS-1:0][DATA_SIZE-1:0] i_data,
  output logic [INPUT_CHANNELS-1:0] o_write_enable,
  output logic [INPUT_CHANNELS-1:0][DATA_SIZE-1:0] o_data,
  output logic [COUNT_WIDTH-1:0] o_count,
  output logic [ADDR_WIDTH-1:0] o_ibuf_addr,
  output logic o_xbar_valid,
  input  logic i_xbar_ready,
  output logic o_xbar_last,
  output logic o_frame_done
`ifdef CONV_IBUF_CTRL_PERF_EN
  ,
  output logic [31:0] o_win_cnt,
  output logic [31:0] o_stall_cnt
`endif
);
  localparam int PW = (IMG_DIM > 1) ? $clog2(IMG_DIM) : 1;
  localparam logic [PW-1:0] P_LAST = PW'(IMG_DIM - 1);
  localparam logic [PW-1:0] K_M1 = PW'(KERNEL_DIM - 1);
  localparam logic [COUNT_WIDTH-1:0] C_LAST = COUNT_WIDTH'(DATA_SIZE - 1);
  localparam logic [ADDR_WIDTH-1:0] A_LAST = ADDR_WIDTH'(NUM_ADDR - 1);
  typedef enum logic {ACCEPT, STREAM} state_t;
  state_t state, state_nx;
  logic [PW-1:0] row, col;
  logic accept, win_full, chunk, addr_last, cnt_last;
  assign accept = i_valid && o_ready;
  assign win_full = row >= K_M1 && col >= K_M1;
  assign chunk = o_xbar_valid && i_xbar_ready;
  assign addr_last = o_ibuf_addr == A_LAST;
  assign cnt_last = o_count == C_LAST;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= ACCEPT;
    else state <= state_nx;
  always_comb
    state_nx = (state == ACCEPT) ? ((accept && win_full) ? STREAM : ACCEPT)
                                 : ((chunk && o_xbar_last) ? ACCEPT : STREAM);
  // o_ready is gated by rst_n so nothing is accepted while reset is held
  always_comb begin
    o_ready = rst_n && state == ACCEPT;
    o_xbar_valid = state == STREAM;
    o_write_enable = {INPUT_CHANNELS{i_valid && o_ready}};
    o_data = i_data;
    o_xbar_last = o_xbar_valid && cnt_last && addr_last;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      row <= '0;
      col <= '0;
      o_count <= '0;
      o_ibuf_addr <= '0;
      o_frame_done <= 1'b0;
    end else begin
      if (accept) begin
        col <= (col == P_LAST) ? '0 : col + 1'b1;
        if (col == P_LAST) row <= (row == P_LAST) ? '0 : row + 1'b1;
      end
      if (chunk) begin
        o_ibuf_addr <= addr_last ? '0 : o_ibuf_addr + 1'b1;
        if (addr_last) o_count <= cnt_last ? '0 : o_count + 1'b1;
      end
      // row/col wrap to the origin only after the bottom-right pixel, so this marks the frame's final window
      o_frame_done <= chunk && o_xbar_last && row == '0 && col == '0;
    end
`ifdef CONV_IBUF_CTRL_PERF_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      o_win_cnt <= '0;
      o_stall_cnt <= '0;
    end else begin
      if (chunk && o_xbar_last) o_win_cnt <= o_win_cnt + 32'd1;
      if (o_xbar_valid && !i_xbar_ready) o_stall_cnt <= o_stall_cnt + 32'd1;
    end
`endif
endmodule

// File: tb/tb_conv_ibuf_ctrl.sv
// tb_conv_ibuf_ctrl: randomized self-checking bench for conv_ibuf_ctrl (default parameters).
module tb_conv_ibuf_ctrl;
  localparam int IMG = 28, K = 3, DS = 8, NA = 2, BEATS = DS*NA, PIX = IMG*IMG;
  logic clk = 1'b0, rst_n = 1'b0, i_valid = 1'b0, i_xbar_ready = 1'b0;
  logic [1:0][7:0] i_data = '0;
  logic o_ready, o_xbar_valid, o_xbar_last, o_frame_done;
  logic [1:0] o_write_enable;
  logic [1:0][7:0] o_data;
  logic [2:0] o_count;
  logic [0:0] o_ibuf_addr;
`ifdef CONV_IBUF_CTRL_PERF_EN
  logic [31:0] o_win_cnt, o_stall_cnt;
`endif
  int checks = 0, errors = 0;
  conv_ibuf_ctrl dut (
    .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .o_ready(o_ready), .i_data(i_data),
    .o_write_enable(o_write_enable), .o_data(o_data), .o_count(o_count), .o_ibuf_addr(o_ibuf_addr),
    .o_xbar_valid(o_xbar_valid), .i_xbar_ready(i_xbar_ready), .o_xbar_last(o_xbar_last),
    .o_frame_done(o_frame_done)
`ifdef CONV_IBUF_CTRL_PERF_EN
    , .o_win_cnt(o_win_cnt), .o_stall_cnt(o_stall_cnt)
`endif
  );
  always #5 clk = ~clk;

  task automatic do_reset();
    rst_n = 1'b0; i_valid = 1'b0; i_xbar_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic fill(input int n);
    i_valid = 1'b1; i_xbar_ready = 1'b1;
    for (int p = 0; p < n; p++) begin
      i_data = 16'($urandom);
      @(negedge clk);
      checks++;
      if ({o_xbar_valid, o_write_enable} !== 3'b011) begin
        errors++; $display("FAIL fill pix %0d got valid/we %b exp 011", p, {o_xbar_valid, o_write_enable});
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; i_valid = 1'b1; i_xbar_ready = 1'b1; i_data = '0;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if ({o_ready, o_write_enable, o_xbar_valid, o_xbar_last, o_frame_done, o_count, o_ibuf_addr, o_data} !== '0) begin
        errors++; $display("FAIL reset_outputs got %b/%b/%b/%b/%b/%0d/%0d exp all 0", o_ready, o_write_enable,
                           o_xbar_valid, o_xbar_last, o_frame_done, o_count, o_ibuf_addr);
      end
    end
    i_valid = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({o_ready, o_xbar_valid} !== 2'b10) begin
      errors++; $display("FAIL reset_release got ready/valid %b exp 10", {o_ready, o_xbar_valid});
    end
  endtask

  task automatic test_first_window();
    do_reset();
    fill(K*IMG - (IMG - K) - 1 + 1);
    for (int k = 0; k < BEATS; k++) begin
      @(negedge clk);
      checks++;
      if ({o_xbar_valid, o_ready, o_write_enable, o_count, o_ibuf_addr, o_xbar_last} !==
          {1'b1, 1'b0, 2'b00, 3'(k / NA), 1'(k % NA), k == BEATS - 1}) begin
        errors++; $display("FAIL window_beat %0d got v%b r%b we%b c%0d a%0d l%b exp c%0d a%0d l%b", k, o_xbar_valid,
                           o_ready, o_write_enable, o_count, o_ibuf_addr, o_xbar_last, k / NA, k % NA, k == BEATS - 1);
      end
      @(posedge clk); #1;
    end
    @(negedge clk);
    checks++;
    if ({o_ready, o_xbar_valid} !== 2'b10) begin
      errors++; $display("FAIL window_return got ready/valid %b exp 10", {o_ready, o_xbar_valid});
    end
  endtask

  task automatic test_stall();
    do_reset();
    fill(59);
    for (int k = 0; k < BEATS; k++) begin
      if (k == 7) begin
        i_xbar_ready = 1'b0;
        repeat (3) begin
          @(negedge clk);
          checks++;
          if ({o_count, o_ibuf_addr, o_ready, o_write_enable, o_xbar_valid} !== {3'd3, 1'b1, 1'b0, 2'b00, 1'b1}) begin
            errors++; $display("FAIL stall_hold got c%0d a%0d r%b we%b v%b exp c3 a1 r0 we00 v1", o_count, o_ibuf_addr,
                               o_ready, o_write_enable, o_xbar_valid);
          end
          @(posedge clk); #1;
        end
        i_xbar_ready = 1'b1;
      end
      @(negedge clk);
      checks++;
      if ({o_count, o_ibuf_addr} !== {3'(k / NA), 1'(k % NA)}) begin
        errors++; $display("FAIL stall_beat %0d got c%0d a%0d exp c%0d a%0d", k, o_count, o_ibuf_addr, k / NA, k % NA);
      end
      @(posedge clk); #1;
    end
`ifdef CONV_IBUF_CTRL_PERF_EN
    @(negedge clk);
    checks++;
    if (o_stall_cnt !== 32'd3) begin errors++; $display("FAIL perf_stall got %0d exp 3", o_stall_cnt); end
    checks++;
    if (o_win_cnt !== 32'd1) begin errors++; $display("FAIL perf_win got %0d exp 1", o_win_cnt); end
`endif
  endtask

  task automatic test_full_frame();
    int m_pix = 0, m_beat = 0, m_anchor = 0, tot = 0, cyc = 0, hs = 0, wins = 0, fds = 0;
    bit m_stream = 0, m_fd = 0, timeout = 0;
    logic [9:0] got, exp;
    do_reset();
    while (!(tot >= PIX + (K - 1) * IMG + K - 1 && !m_stream)) begin
      if (cyc++ >= 40000) begin timeout = 1; break; end
      i_valid = $urandom_range(0, 9) < 8;
      i_xbar_ready = $urandom_range(0, 3) != 0;
      i_data = 16'($urandom);
      @(negedge clk);
      got = {o_ready, o_xbar_valid, o_write_enable, o_count, o_ibuf_addr, o_xbar_last, o_frame_done};
      exp = {!m_stream, m_stream, (!m_stream && i_valid) ? 2'b11 : 2'b00, m_stream ? 3'(m_beat / NA) : 3'd0,
             m_stream ? 1'(m_beat % NA) : 1'b0, m_stream && m_beat == BEATS - 1, m_fd};
      checks++;
      if (got !== exp) begin
        errors++; $display("FAIL frame_cycle %0d pix %0d got %b exp %b", cyc, m_pix, got, exp);
      end
      checks++;
      if (o_data !== i_data) begin errors++; $display("FAIL frame_data got %h exp %h", o_data, i_data); end
      if (o_xbar_valid && i_xbar_ready) hs++;
      if (o_xbar_last && i_xbar_ready) wins++;
      if (o_frame_done) fds++;
      m_fd = 0;
      if (!m_stream && i_valid) begin
        if (m_pix / IMG >= K - 1 && m_pix % IMG >= K - 1) begin m_stream = 1; m_beat = 0; m_anchor = m_pix; end
        m_pix = (m_pix + 1) % PIX;
        tot++;
      end else if (m_stream && i_xbar_ready) begin
        if (m_beat == BEATS - 1) begin m_stream = 0; m_fd = m_anchor == PIX - 1; end
        else m_beat++;
      end
      @(posedge clk); #1;
    end
    checks++;
    if (timeout) begin errors++; $display("FAIL frame_timeout got %0d pixels exp %0d", tot, PIX + 58); end
    checks++;
    if (hs != 10816) begin errors++; $display("FAIL frame_handshakes got %0d exp 10816", hs); end
    checks++;
    if (wins != 676) begin errors++; $display("FAIL frame_windows got %0d exp 676", wins); end
    checks++;
    if (fds != 1) begin errors++; $display("FAIL frame_done_pulses got %0d exp 1", fds); end
  endtask

  task automatic test_reset_mid_stream();
    do_reset();
    fill(59);
    repeat (4) @(posedge clk);
    #1;
    @(negedge clk);
    checks++;
    if ({o_xbar_valid, o_count, o_ibuf_addr} !== {1'b1, 3'd2, 1'b0}) begin
      errors++; $display("FAIL midrst_pre got v%b c%0d a%0d exp v1 c2 a0", o_xbar_valid, o_count, o_ibuf_addr);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({o_xbar_valid, o_count, o_ibuf_addr, o_ready} !== '0) begin
      errors++; $display("FAIL midrst_abort got v%b c%0d a%0d r%b exp all 0", o_xbar_valid, o_count, o_ibuf_addr, o_ready);
    end
    @(posedge clk); @(posedge clk);
    #1 rst_n = 1'b1;
    fill(59);
    @(negedge clk);
    checks++;
    if ({o_xbar_valid, o_count, o_ibuf_addr} !== {1'b1, 3'd0, 1'b0}) begin
      errors++; $display("FAIL midrst_refill got v%b c%0d a%0d exp v1 c0 a0", o_xbar_valid, o_count, o_ibuf_addr);
    end
  endtask

  initial begin
    test_reset();
    test_first_window();
    test_stall();
    test_full_frame();
    test_reset_mid_stream();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
